// File: rtl/regfile_rename.sv
// -----------------------------------------------------------------------------
// regfile_rename
//   Architectural register file with per-register rename status. Each register
//   carries a value, a busy bit and the ROB tag of its pending producer. It
//   sits between decode/dispatch (operand reads, renames) and ROB commit.
//
// Ports
//   clk_in, rst_n_in   clock (rising edge), asynchronous active-low reset
//   rdy_in             low = pause: state holds, reads stay live
//   iss_en/rd/tag      rename: mark iss_rd busy, waiting on ROB entry iss_tag
//   cmt_en/rd/tag/value commit: write the value; clear busy if the tag matches
//   flush              clear every busy bit and tag (values are kept)
//   rd_idx             NUM_RD*2 read indices (even slot = rs1, odd slot = rs2)
//   rd_busy/value/tag  per-slot operand status, combinational
//   busy_count         registered number of busy registers
// -----------------------------------------------------------------------------
module regfile_rename #(
  parameter int XLEN    = 32,
  parameter int REG_BIT = 5,
  parameter int ROB_BIT = 4,
  parameter int NUM_RD  = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          iss_en,
  input  logic [REG_BIT-1:0]            iss_rd,
  input  logic [ROB_BIT-1:0]            iss_tag,
  input  logic                          cmt_en,
  input  logic [REG_BIT-1:0]            cmt_rd,
  input  logic [ROB_BIT-1:0]            cmt_tag,
  input  logic [XLEN-1:0]               cmt_value,
  input  logic                          flush,
  input  logic [NUM_RD*2*REG_BIT-1:0]   rd_idx,
  output logic [NUM_RD*2-1:0]           rd_busy,
  output logic [NUM_RD*2*XLEN-1:0]      rd_value,
  output logic [NUM_RD*2*ROB_BIT-1:0]   rd_tag,
  output logic [REG_BIT:0]              busy_count
);

  localparam int NUM_REGS  = 1 << REG_BIT;
  localparam int NUM_SLOTS = NUM_RD * 2;

  logic [XLEN-1:0]    regs_q [NUM_REGS];
  logic [XLEN-1:0]    regs_d [NUM_REGS];
  logic [ROB_BIT-1:0] tag_q  [NUM_REGS];
  logic [ROB_BIT-1:0] tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_BIT:0]    count_q, count_d;

  logic iss_ok, cmt_ok, cmt_match, cnt_inc, cnt_dec;

  // x0 is hard-wired: writes addressed to it never touch state.
  assign iss_ok    = iss_en && (iss_rd != '0);
  assign cmt_ok    = cmt_en && (cmt_rd != '0);
  assign cmt_match = cmt_ok && busy_q[cmt_rd] && (tag_q[cmt_rd] == cmt_tag);

  // A same-register issue+commit nets to zero: the register was already busy
  // (so no increment) and stays busy (so no decrement).
  assign cnt_inc = iss_ok && !flush && !busy_q[iss_rd];
  assign cnt_dec = cmt_match && !flush && !(iss_ok && (iss_rd == cmt_rd));

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    count_d = count_q;
    if (rdy_in) begin
      if (cmt_ok) begin
        regs_d[cmt_rd] = cmt_value;
        // A younger rename has replaced the tag; keep the register busy.
        if (tag_q[cmt_rd] == cmt_tag) busy_d[cmt_rd] = 1'b0;
      end
      if (flush) begin
        busy_d  = '0;
        count_d = '0;
        for (int r = 0; r < NUM_REGS; r++) tag_d[r] = '0;
      end else begin
        // Issue is applied after commit so it wins on the same register.
        if (iss_ok) begin
          busy_d[iss_rd] = 1'b1;
          tag_d[iss_rd]  = iss_tag;
        end
        count_d = count_q + {{REG_BIT{1'b0}}, cnt_inc} - {{REG_BIT{1'b0}}, cnt_dec};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  // NOTE: the register array is reset explicitly because the architectural
  // state must read as zero right after reset; this rules out a RAM macro.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q  <= '0;
      count_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
        tag_q[r]  <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
        tag_q[r]  <= tag_d[r];
      end
    end
  end

  assign busy_count = count_q;

  // Operand reads see pre-issue state; a matching commit in the same cycle is
  // forwarded so dispatch does not wait a cycle for a value already on the bus.
  logic [REG_BIT-1:0] slot_idx [NUM_SLOTS];

  always_comb begin
    rd_busy  = '0;
    rd_value = '0;
    rd_tag   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_idx[k] = rd_idx[k*REG_BIT +: REG_BIT];
      if (slot_idx[k] != '0) begin
        if (cmt_en && (cmt_rd == slot_idx[k]) && busy_q[slot_idx[k]] &&
            (tag_q[slot_idx[k]] == cmt_tag)) begin
          rd_value[k*XLEN +: XLEN] = cmt_value;
        end else if (busy_q[slot_idx[k]]) begin
          rd_busy[k]                   = 1'b1;
          rd_tag[k*ROB_BIT +: ROB_BIT] = tag_q[slot_idx[k]];
        end else begin
          rd_value[k*XLEN +: XLEN] = regs_q[slot_idx[k]];
        end
      end
    end
  end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with per-register rename status (busy bit + ROB tag). Generalised successor of the single-port register status table.
- Serves NUM_RD decoder read pairs combinationally, with commit-to-read bypass.
- Accepts one rename (issue) write and one commit write per cycle, plus a global flush on misprediction.
- Sits between decoder/dispatch and ROB commit.

Parameters:
XLEN, 32, data width of each register
REG_BIT, 5, register index width; NUM_REGS = 2**REG_BIT
ROB_BIT, 4, ROB tag width
NUM_RD, 2, number of rs1/rs2 read pairs (decode width)

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  low = pause; state holds, reads still valid
iss_en  input  1  rename write: mark iss_rd busy with iss_tag
iss_rd  input  REG_BIT  destination register being renamed
iss_tag  input  ROB_BIT  ROB entry producing iss_rd
cmt_en  input  1  commit write
cmt_rd  input  REG_BIT  committed destination register
cmt_tag  input  ROB_BIT  ROB entry committing
cmt_value  input  XLEN  committed result
flush  input  1  clear all busy bits (values kept)
rd_idx  input  NUM_RD*2*REG_BIT  read indices; slot k = rs1 of pair k/2 for even k, rs2 for odd k
rd_busy  output  NUM_RD*2  1 = operand pending in ROB
rd_value  output  NUM_RD*2*XLEN  operand value; 0 when busy
rd_tag  output  NUM_RD*2*ROB_BIT  pending ROB tag; 0 when not busy
busy_count  output  REG_BIT+1  registered count of busy registers

Behaviour:
- Reset (rst_n_in low, asynchronous): all regs = 0, busy = 0, tags = 0, busy_count = 0. Reads reflect this immediately.
- rdy_in low: no state update; combinational reads continue from current state.
- x0: writes of any kind to index 0 ignored; reads of 0 always give busy = 0, value = 0, tag = 0.
- Reads are combinational, zero latency, per slot:
  - If cmt_en && cmt_rd == idx && busy[idx] && tag[idx] == cmt_tag (bypass): busy = 0, value = cmt_value.
  - Else if busy[idx]: busy = 1, value = 0, tag = tag[idx].
  - Else: busy = 0, value = regs[idx], tag = 0.
  - Bypass is not suppressed by a same-cycle iss_en to that register. Reads see pre-issue state; dispatch handles intra-group dependencies.
- Commit (posedge, rdy_in high, cmt_en, cmt_rd != 0):
  - regs[cmt_rd] <= cmt_value, always.
  - busy[cmt_rd] <= 0 only if tag[cmt_rd] == cmt_tag. A younger rename keeps the register busy.
- Issue (posedge, rdy_in high, iss_en, iss_rd != 0): busy[iss_rd] <= 1, tag[iss_rd] <= iss_tag.
- Same cycle, same register, issue + commit: value written; busy = 1 and tag = iss_tag (issue wins).
- Flush (rdy_in high): all busy <= 0, tags <= 0. Same-cycle commit value is still written. Same-cycle issue is discarded. Flush has priority over issue.
- busy_count:
  - Updated each enabled edge: +1 for an issue that newly sets a non-busy register; -1 for a matched commit not overridden by a same-cycle issue to that register.
  - Flush → 0.
  - Never exceeds NUM_REGS-1 and never underflows.
- Multiple read slots may address the same register; all slots return identical results.

Test Plan:
- Reset, then read x5 on all 4 slots → busy 0, value 0, tag 0; busy_count 0.
- Issue x5 tag 3; next cycle read x5 → busy 1, tag 3, value 0; busy_count 1. Commit x5 tag 3 value 0xDEADBEEF → same-cycle read shows busy 0, value 0xDEADBEEF; next cycle busy 0; busy_count 0.
- Issue x7 tag 2, then issue x7 tag 9; commit x7 tag 2 value 0x11 → x7 stays busy, tag 9, regs[7] = 0x11, busy_count 1. No bypass on tag 2.
- Same cycle: issue x4 tag 6 and matching commit x4 value 0x22 → x4 busy, tag 6, regs[4] = 0x22; busy_count unchanged.
- Issue x1..x3 (tags 1,2,3), then flush with same-cycle issue x8 → all not busy; x8 not busy; busy_count 0; earlier values intact.
- Issue x0 tag 5, commit x0 value 0x99; rdy_in low during issue x6 → x0 reads 0/not busy; x6 unchanged; asserting rst_n_in mid-stream clears busy immediately without a clock edge.
